// File: rtl/mesh_edge_endpoint.sv
// mesh_edge_endpoint
// Link-partner endpoint for one cardinal port of a cardinal_node router.
//   TX: host pushes 64-bit packets into a small FIFO; the endpoint injects
//       them on link_so/link_do when the router is ready (link_ro). If
//       polarity gating is on, a packet goes out only when its VC bit
//       (bit 63) matches the local link polarity.
//   RX: packets arriving on link_si/link_di are queued in a FIFO that the
//       host drains with rx_pop/rx_data. link_ri advertises free space.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   link_so/link_do       send strobe + data toward the router input
//   link_ro               router input ready
//   link_si/link_di       send strobe + data from the router output
//   link_ri               endpoint ready toward the router output
//   tx_push/tx_data/tx_full   host TX FIFO interface
//   rx_pop/rx_data/rx_empty   host RX FIFO interface (rx_data = head)
//   polarity              link phase, toggles every cycle
//   tx_count/rx_count     wrapping packet counters
//   err                   sticky overflow / protocol error flag
module mesh_edge_endpoint #(
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 4,
  parameter int CNT_W        = 16,
  parameter int USE_POLARITY = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             link_so,
  output logic [63:0]      link_do,
  input  logic             link_ro,
  input  logic             link_si,
  input  logic [63:0]      link_di,
  output logic             link_ri,
  input  logic             tx_push,
  input  logic [63:0]      tx_data,
  output logic             tx_full,
  input  logic             rx_pop,
  output logic [63:0]      rx_data,
  output logic             rx_empty,
  output logic             polarity,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic             err
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  // Storage arrays: contents need no reset, only the pointers do.
  logic [63:0] tx_mem [TX_DEPTH];
  logic [63:0] rx_mem [RX_DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [TX_AW:0]   tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [RX_AW:0]   rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic             link_so_q, link_so_d;
  logic [63:0]      link_do_q, link_do_d;
  logic             link_ri_q, link_ri_d;
  logic             polarity_q, polarity_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d;
  logic [CNT_W-1:0] rx_count_q, rx_count_d;
  logic             err_q, err_d;

  logic        tx_empty_w, tx_full_w, rx_empty_w, rx_full_next;
  logic [63:0] tx_head;
  logic        tx_send, tx_push_ok, rx_wr, rx_rd;

  assign tx_empty_w = (tx_wp_q == tx_rp_q);
  assign tx_full_w  = (tx_wp_q[TX_AW] != tx_rp_q[TX_AW]) &&
                      (tx_wp_q[TX_AW-1:0] == tx_rp_q[TX_AW-1:0]);
  assign rx_empty_w = (rx_wp_q == rx_rp_q);
  assign tx_head    = tx_mem[tx_rp_q[TX_AW-1:0]];

  // A send needs a queued packet, a ready router and an idle cycle since the
  // previous send (covers the router's ri update latency).
  assign tx_send    = !tx_empty_w && link_ro && !link_so_q &&
                      ((USE_POLARITY == 0) || (tx_head[63] == polarity_q));
  assign tx_push_ok = tx_push && !tx_full_w;
  // The router may only send while we advertised ready; otherwise the
  // packet is dropped and flagged.
  assign rx_wr      = link_si && link_ri_q;
  assign rx_rd      = rx_pop && !rx_empty_w;

  always_comb begin
    tx_wp_d    = tx_wp_q;
    tx_rp_d    = tx_rp_q;
    rx_wp_d    = rx_wp_q;
    rx_rp_d    = rx_rp_q;
    link_so_d  = 1'b0;
    link_do_d  = link_do_q;
    polarity_d = !polarity_q;
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    err_d      = err_q;

    if (tx_send) begin
      link_so_d  = 1'b1;
      link_do_d  = tx_head;
      tx_rp_d    = tx_rp_q + 1'b1;
      tx_count_d = tx_count_q + 1'b1;
    end
    if (tx_push_ok) begin
      tx_wp_d = tx_wp_q + 1'b1;
    end
    if (rx_rd) begin
      rx_rp_d = rx_rp_q + 1'b1;
    end
    if (rx_wr) begin
      rx_wp_d    = rx_wp_q + 1'b1;
      rx_count_d = rx_count_q + 1'b1;
    end
    if ((tx_push && tx_full_w) || (link_si && !link_ri_q)) begin
      err_d = 1'b1;
    end
  end

  // Ready is registered from the post-edge occupancy so it tracks the
  // FIFO on the same edge the count changes.
  assign rx_full_next = (rx_wp_d[RX_AW] != rx_rp_d[RX_AW]) &&
                        (rx_wp_d[RX_AW-1:0] == rx_rp_d[RX_AW-1:0]);
  assign link_ri_d    = !rx_full_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      link_so_q  <= 1'b0;
      link_do_q  <= '0;
      link_ri_q  <= 1'b0;
      polarity_q <= 1'b0;
      tx_count_q <= '0;
      rx_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      link_so_q  <= link_so_d;
      link_do_q  <= link_do_d;
      link_ri_q  <= link_ri_d;
      polarity_q <= polarity_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push_ok && !reset) begin
      tx_mem[tx_wp_q[TX_AW-1:0]] <= tx_data;
    end
    if (rx_wr && !reset) begin
      rx_mem[rx_wp_q[RX_AW-1:0]] <= link_di;
    end
  end

  assign link_so  = link_so_q;
  assign link_do  = link_do_q;
  assign link_ri  = link_ri_q;
  assign tx_full  = tx_full_w;
  assign rx_empty = rx_empty_w;
  assign rx_data  = rx_empty_w ? 64'd0 : rx_mem[rx_rp_q[RX_AW-1:0]];
  assign polarity = polarity_q;
  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;
  assign err      = err_q;

endmodule
